// File: rtl/wb_retire.sv
// Writeback/retire stage: in-order result FIFO driving the regfile write port.
// Optional decode forwarding from pending results when WB_BYPASS_EN is defined.
module wb_retire #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_regwrite,
  input  logic                     in_memtoreg,
  input  logic [AW-1:0]            in_rd,
  input  logic [DW-1:0]            in_alu,
  input  logic [DW-1:0]            in_mem,
  input  logic                     wb_hold,
  output logic                     rw,
  output logic [DW-1:0]            wd,
  output logic [AW-1:0]            rdi,
  input  logic [AW-1:0]            rs_a,
  input  logic [AW-1:0]            rs_b,
  output logic                     fwd_a_hit,
  output logic [DW-1:0]            fwd_a_data,
  output logic                     fwd_b_hit,
  output logic [DW-1:0]            fwd_b_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_rd [DEPTH];
  logic [DW-1:0] q_d  [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          push, pop;

  assign count    = cnt;
  assign in_ready = (cnt != CW'(DEPTH));
  assign push     = in_valid & in_ready & in_regwrite;
  assign pop      = (cnt != '0) & ~wb_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      rw   <= 1'b0;
      wd   <= '0;
      rdi  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      rw <= pop;
      if (pop) begin
        wd  <= q_d[rptr];
        rdi <= q_rd[rptr];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr] <= in_rd;
      q_d[wptr]  <= in_memtoreg ? in_mem : in_alu;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Oldest first so the newest (tail-most) match overwrites; output reg lowest.
  always_comb begin
    idx        = '0;
    fwd_a_hit  = rw && (rdi == rs_a);
    fwd_a_data = fwd_a_hit ? wd : '0;
    fwd_b_hit  = rw && (rdi == rs_b);
    fwd_b_data = fwd_b_hit ? wd : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (CW'(k) < cnt) begin
        if (q_rd[idx] == rs_a) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = q_d[idx];
        end
        if (q_rd[idx] == rs_b) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = q_d[idx];
        end
      end
    end
  end
`else
  logic unused_rs;
  assign unused_rs  = ^{rs_a, rs_b};
  assign fwd_a_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_wb_retire.sv
// Scoreboard bench for wb_retire: accepted writes queued, retired writes
// popped and compared by a negedge monitor.
module tb_wb_retire;

  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic                   clk, rst;
  logic                   in_valid, in_ready, in_regwrite, in_memtoreg;
  logic [AW-1:0]          in_rd;
  logic [DW-1:0]          in_alu, in_mem;
  logic                   wb_hold;
  logic                   rw;
  logic [DW-1:0]          wd;
  logic [AW-1:0]          rdi;
  logic [AW-1:0]          rs_a, rs_b;
  logic                   fwd_a_hit, fwd_b_hit;
  logic [DW-1:0]          fwd_a_data, fwd_b_data;
  logic [$clog2(DEPTH):0] count;

  wb_retire #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem),
    .wb_hold(wb_hold),
    .rw(rw), .wd(wd), .rdi(rdi),
    .rs_a(rs_a), .rs_b(rs_b),
    .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
    .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+DW-1:0] exp_q [$];
  logic [AW+DW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rw === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got rdi=%0d wd=0x%0h, expected none",
                 rdi, wd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("retire_rdi", 32'(rdi), 32'(mon_e[DW+:AW]));
        chk("retire_wd", wd, mon_e[DW-1:0]);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic offer(input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mem, input logic m2r,
                       input logic regw);
    in_rd       = rd;
    in_alu      = alu;
    in_mem      = mem;
    in_memtoreg = m2r;
    in_regwrite = regw;
    in_valid    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        if (regw) exp_q.push_back({rd, m2r ? mem : alu});
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL offer_timeout: got no accept for rd=%0d, expected accept", rd);
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_regwrite = 1'b0;
    in_memtoreg = 1'b0;
    in_rd = '0;
    in_alu = '0;
    in_mem = '0;
    wb_hold = 1'b0;
    rs_a = '0;
    rs_b = '0;
    cyc(2);
    chk("rst_rw", 32'(rw), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_fwd_a", 32'(fwd_a_hit), 0);
    rst = 1'b0;
    cyc(1);

    // single write latency
    offer(6'd5, 32'h11, 32'h0, 1'b0, 1'b1);
    chk("lat_edge_n_rw", 32'(rw), 0);
    cyc(1);
    chk("lat_rw", 32'(rw), 1);
    chk("lat_rdi", 32'(rdi), 5);
    chk("lat_wd", wd, 32'h11);
    cyc(1);
    chk("lat_rw_drop", 32'(rw), 0);

    // hold, fill, refuse 5th, drain in order
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++)
      offer(AW'(i), 32'hDEAD0000 + i, 32'hA0 + i, 1'b1, 1'b1);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    in_rd = 6'd9;
    in_regwrite = 1'b1;
    in_valid = 1'b1;
    cyc(3);
    chk("full_no_accept", 32'(count), 4);
    in_valid = 1'b0;
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("drain_rw", 32'(rw), 1);
    end
    cyc(1);
    chk("drain_done", 32'(rw), 0);

    // non-writing result
    offer(6'd12, 32'h55, 32'h66, 1'b0, 1'b0);
    chk("noregw_count", 32'(count), 0);
    cyc(4);

    // reset mid-stream
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++)
      offer(AW'(20 + i), 32'h700 + i, 32'h0, 1'b0, 1'b1);
    wb_hold = 1'b0;
    cyc(1);
    chk("pre_rst_rw", 32'(rw), 1);
    chk("pre_rst_count", 32'(count), 3);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_rw", 32'(rw), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    cyc(2);
    rst = 1'b0;
    cyc(6);

    // streaming with pointer wrap, 12 writes
    wb_hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) wb_hold = 1'b0;
      offer(AW'(30 + i), 32'h300 + i, 32'h400 + i, (i % 2) == 1, 1'b1);
    end
    cyc(8);
    chk("stream_count", 32'(count), 0);

    // forwarding
    wb_hold = 1'b1;
    rs_a = 6'd7;
    rs_b = 6'd3;
    offer(6'd7, 32'h100, 32'h0, 1'b0, 1'b1);
    offer(6'd7, 32'h200, 32'h0, 1'b0, 1'b1);
`ifdef WB_BYPASS_EN
    chk("fwd_a_hit", 32'(fwd_a_hit), 1);
    chk("fwd_a_data", fwd_a_data, 32'h200);
    chk("fwd_b_hit", 32'(fwd_b_hit), 0);
`else
    chk("fwd_a_hit", 32'(fwd_a_hit), 0);
    chk("fwd_a_data", fwd_a_data, 0);
    chk("fwd_b_hit", 32'(fwd_b_hit), 0);
`endif
    wb_hold = 1'b0;
    cyc(6);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
